// File: rtl/clkdiv_meter.sv
// Measures the rise-to-rise spacing of a divided clock in clk_i cycles, locks once two
// consecutive legal (power-of-two, 2..256) periods agree, and flags loss of the clock.
module clkdiv_meter #(
  parameter int unsigned TIMEOUT = 511
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       dclk_i,
  output logic [8:0] period_o,
  output logic [2:0] sel_o,
  output logic       valid_o,
  output logic       lost_o
);

  localparam logic [8:0] CntMax     = 9'd511;
  localparam logic [8:0] TimeoutCnt = 9'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StMeas, StLock} state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q, dly_q;
  logic       rise;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] prev_q, prev_d;
  logic [8:0] period_q, period_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       lost_q, lost_d;
  logic       period_legal;
  logic       timeout;
  logic       lock_entry;

  function automatic logic is_legal(input logic [8:0] p);
    return (p >= 9'd2) && (p <= 9'd256) && ((p & (p - 9'd1)) == 9'd0);
  endfunction

  function automatic logic [2:0] sel_decode(input logic [8:0] p);
    logic [2:0] s;
    s = 3'd0;
    case (p)
      9'd2:    s = 3'd0;
      9'd4:    s = 3'd1;
      9'd8:    s = 3'd2;
      9'd16:   s = 3'd3;
      9'd32:   s = 3'd4;
      9'd64:   s = 3'd5;
      9'd128:  s = 3'd6;
      9'd256:  s = 3'd7;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  assign rise         = sync2_q & ~dly_q;
  assign period_legal = is_legal(cnt_q);
  // A rise in the same cycle as the timeout count takes priority.
  assign timeout      = (state_q != StIdle) && !rise && (cnt_q == TimeoutCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = 9'd1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; cnt_q at a rise is the period just measured.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StMeas;
        end
      end
      StMeas: begin
        if (rise) begin
          prev_d = cnt_q;
          if (period_legal && (cnt_q == prev_q)) begin
            state_d = StLock;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StLock: begin
        if (rise) begin
          if (cnt_q != prev_q) begin
            state_d = StMeas;
            prev_d  = cnt_q;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; period/sel only load on LOCK entry so they hold steady while locked.
  always_comb begin
    lock_entry = (state_q != StLock) && (state_d == StLock);
    period_d   = period_q;
    sel_d      = sel_q;
    if (lock_entry) begin
      period_d = cnt_q;
      sel_d    = sel_decode(cnt_q);
    end
    valid_d = (state_d == StLock);
    lost_d  = lost_q;
    if (timeout) begin
      lost_d = 1'b1;
    end else if ((state_q == StIdle) && rise) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      dly_q    <= 1'b0;
      cnt_q    <= 9'd0;
      prev_q   <= 9'd0;
      period_q <= 9'd0;
      sel_q    <= 3'd0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      sync1_q  <= dclk_i;
      sync2_q  <= sync1_q;
      dly_q    <= sync2_q;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      period_q <= period_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  assign period_o = period_q;
  assign sel_o    = sel_q;
  assign valid_o  = valid_q;
  assign lost_o   = lost_q;

`ifndef SYNTHESIS
  valid_implies_legal: assert property (@(posedge clk_i) disable iff (!rstn_i)
    valid_o |-> is_legal(period_o));
  lost_excludes_valid: assert property (@(posedge clk_i) disable iff (!rstn_i)
    lost_o |-> !valid_o);
`endif

endmodule

// File: tb/tb_clkdiv_meter.sv
// Bench for clkdiv_meter: an edge-indexed period model checked every cycle, plus literal
// checkpoints for lock, select change, jitter, loss of clock, reset and timeout priority.
module tb_clkdiv_meter;

  localparam int Timeout = 511;

  logic       clk;
  logic       rstn;
  logic       dclk;
  logic [8:0] period;
  logic [2:0] sel;
  logic       valid;
  logic       lost;

  int vectors     = 0;
  int miscompares = 0;

  clkdiv_meter #(.TIMEOUT(Timeout)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .dclk_i  (dclk),
    .period_o(period),
    .sel_o   (sel),
    .valid_o (valid),
    .lost_o  (lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: edges are numbered; the design acts on a dclk rise two edges after sampling it,
  // and the measured period is the edge distance between consecutive acted-on rises.
  int m_state = 0;  // 0 idle, 1 measuring, 2 locked
  int m_prev  = 0;
  int m_base  = 0;
  int m_edge  = 0;
  bit m_hist [3];
  int exp_period = 0;
  int exp_sel    = 0;
  bit exp_valid  = 1'b0;
  bit exp_lost   = 1'b0;

  function automatic bit legal(input int p);
    return (p >= 2) && (p <= 256) && ((p & (p - 1)) == 0);
  endfunction

  task automatic model_step(input bit r, input bit d);
    int p;
    bit rise;
    m_edge++;
    if (!r) begin
      m_state    = 0;
      m_prev     = 0;
      m_base     = m_edge;
      m_hist     = '{default: 1'b0};
      exp_period = 0;
      exp_sel    = 0;
      exp_valid  = 1'b0;
      exp_lost   = 1'b0;
    end else begin
      rise = m_hist[1] && !m_hist[2];
      p    = m_edge - 1 - m_base;
      if (p > 511) p = 511;
      if (rise) begin
        if (m_state == 0) begin
          m_state  = 1;
          exp_lost = 1'b0;
        end else if (m_state == 1) begin
          if (legal(p) && p == m_prev) begin
            m_state    = 2;
            exp_period = p;
            exp_sel    = $clog2(p) - 1;
          end
          m_prev = p;
        end else if (p != m_prev) begin
          m_state = 1;
          m_prev  = p;
        end
        m_base = m_edge - 1;
      end else if (m_state != 0 && p == Timeout) begin
        m_state  = 0;
        exp_lost = 1'b1;
      end
      exp_valid = (m_state == 2);
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = d;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step(rstn, dclk);
      vectors++;
      if (period !== 9'(exp_period) || sel !== 3'(exp_sel) || valid !== exp_valid ||
          lost !== exp_lost) begin
        miscompares++;
        if (miscompares <= 20) begin
          $display("FAIL cycle %0d: got period=%0d sel=%0d valid=%0b lost=%0b, expected period=%0d sel=%0d valid=%0b lost=%0b",
                   m_edge, period, sel, valid, lost, exp_period, exp_sel, exp_valid, exp_lost);
        end
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // n periods of length p, high for p/2 cycles; inputs change on the falling edge.
  task automatic drive(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        dclk = (c < p / 2);
      end
    end
  endtask

  task automatic wait_low(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      dclk = 1'b0;
    end
  endtask

  initial begin
    rstn = 1'b0;
    dclk = 1'b0;
    repeat (4) @(negedge clk);
    lit("reset_period", int'(period), 0);
    lit("reset_sel", int'(sel), 0);
    lit("reset_valid", int'(valid), 0);
    lit("reset_lost", int'(lost), 0);
    rstn = 1'b1;

    drive(8, 4);
    lit("steady8_valid", int'(valid), 1);
    lit("steady8_period", int'(period), 8);
    lit("steady8_sel", int'(sel), 2);
    drive(8, 4);
    lit("steady8_hold", int'(valid), 1);

    drive(9, 1);
    drive(8, 1);
    lit("jitter_drop", int'(valid), 0);
    lit("jitter_keep_period", int'(period), 8);
    drive(8, 3);
    lit("jitter_relock", int'(valid), 1);
    lit("jitter_period", int'(period), 8);

    drive(2, 8);
    lit("p2_valid", int'(valid), 1);
    lit("p2_period", int'(period), 2);
    lit("p2_sel", int'(sel), 0);
    drive(256, 2);
    lit("p256_drop", int'(valid), 0);
    lit("p256_keep_sel", int'(sel), 0);
    drive(256, 1);
    lit("p256_valid", int'(valid), 1);
    lit("p256_period", int'(period), 256);
    lit("p256_sel", int'(sel), 7);

    drive(16, 4);
    lit("p16_period", int'(period), 16);
    lit("p16_sel", int'(sel), 3);
    repeat (498) @(negedge clk);
    lit("stop_pre_lost", int'(lost), 0);
    lit("stop_pre_valid", int'(valid), 1);
    @(negedge clk);
    lit("stop_lost", int'(lost), 1);
    lit("stop_valid", int'(valid), 0);
    lit("stop_keep_period", int'(period), 16);
    drive(16, 1);
    lit("resume_lost_clear", int'(lost), 0);
    drive(16, 3);
    lit("resume_valid", int'(valid), 1);
    lit("resume_period", int'(period), 16);

    drive(32, 4);
    lit("p32_valid", int'(valid), 1);
    lit("p32_sel", int'(sel), 4);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    lit("midreset_valid", int'(valid), 0);
    lit("midreset_period", int'(period), 0);
    lit("midreset_sel", int'(sel), 0);
    rstn = 1'b1;
    drive(32, 4);
    lit("relock32_valid", int'(valid), 1);
    lit("relock32_period", int'(period), 32);
    lit("relock32_sel", int'(sel), 4);

    drive(6, 40);
    lit("p6_valid", int'(valid), 0);
    lit("p6_lost", int'(lost), 0);
    lit("p6_keep_period", int'(period), 32);

    wait_low(505);
    drive(4, 1);
    lit("rise_beats_timeout", int'(lost), 0);
    wait_low(520);
    lit("meas_timeout_lost", int'(lost), 1);
    drive(8, 4);
    lit("final_valid", int'(valid), 1);
    lit("final_lost", int'(lost), 0);
    lit("final_period", int'(period), 8);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
